// File: rtl/risc_v_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/ack plus decoder-facing outputs.
// No latency of its own; it only carries wires.
// Backpressure: imem_ack gates the request side, decode_ready gates the hold side.
interface risc_v_fetch_unit_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   imem_req;
    logic [WORD_LENGTH-1:0] imem_addr;
    logic                   imem_ack;
    logic [WORD_LENGTH-1:0] imem_rdata;
    logic                   decode_ready;
    logic                   instr_valid;
    logic [WORD_LENGTH-1:0] instr;
    logic [WORD_LENGTH-1:0] pc;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic                   funct7;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [WORD_LENGTH-1:0] imm_i;
    logic                   illegal;
    logic [WORD_LENGTH-1:0] instr_count;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, pc, opcode, funct3, funct7,
               rd, rs1, rs2, imm_i, illegal, instr_count,
        input  imem_ack, imem_rdata, decode_ready
    );

    // Memory / decoder side
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, pc, opcode, funct3, funct7,
               rd, rs1, rs2, imm_i, illegal, instr_count,
        output imem_ack, imem_rdata, decode_ready
    );
endinterface

// File: rtl/risc_v_fetch_unit.sv
// Instruction fetch: holds PC, single outstanding imem request, registers the fetched word.
// Latency: word visible one cycle after the acked request cycle; peak rate one instr per 2 cycles.
// Backpressure: instruction held (pc/instr frozen) until decode_ready; request held until imem_ack.
module risc_v_fetch_unit #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    risc_v_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [WORD_LENGTH-1:0] pc_q;
    logic [WORD_LENGTH-1:0] pc_d;
    logic                   req_q;
    logic                   valid_q;
    logic [WORD_LENGTH-1:0] instr_q;
    logic [WORD_LENGTH-1:0] count_q;
    logic [WORD_LENGTH-1:0] count_d;

    // Both advance values wrap naturally at the word width.
    assign pc_d    = pc_q + WORD_LENGTH'(4);
    assign count_d = count_q + WORD_LENGTH'(1);

    // Fetch FSM: request until ack, hold until consumed, then step the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Abandons any in-flight request; a same-cycle ack is dropped.
            state_q <= S_START;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_START: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.decode_ready) begin
                        pc_q    <= pc_d;
                        count_q <= count_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_START;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_count = count_q;

    // Decoder fields are plain slices of the held word.
    assign bus.opcode = instr_q[6:0];
    assign bus.funct3 = instr_q[14:12];
    assign bus.funct7 = instr_q[30];
    assign bus.rd     = instr_q[11:7];
    assign bus.rs1    = instr_q[19:15];
    assign bus.rs2    = instr_q[24:20];
    assign bus.imm_i  = {{(WORD_LENGTH-12){instr_q[31]}}, instr_q[31:20]};

    // Only OP-IMM and OP are handled downstream; everything else is flagged.
    assign bus.illegal = valid_q && (instr_q[6:0] != 7'b0010011) && (instr_q[6:0] != 7'b0110011);
endmodule

// File: doc/risc_v_fetch_unit.md
Name: risc_v_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the RISC-V control unit. It holds the PC and runs a request/acknowledge handshake with instruction memory. It registers each fetched word and presents the decoder-facing fields (opcode, funct3, funct7 select bit), plus register indices and I-immediate for the register file and ALU. It advances the PC only after the downstream stage has consumed the current instruction.

Parameters:
- WORD_LENGTH, 32, width of PC, instruction, immediate and counter.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  registered fetch request to instruction memory.
- imem_addr  output  WORD_LENGTH  fetch address; equals pc.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  WORD_LENGTH  instruction word; valid only when imem_ack=1.
- decode_ready  input  1  downstream accepts the held instruction this cycle.
- instr_valid  output  1  instr and the decoded fields are valid.
- instr  output  WORD_LENGTH  registered instruction word.
- pc  output  WORD_LENGTH  address of the held or in-flight instruction.
- opcode  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7  output  1  instr[30]; selects SUB vs ADD and SRA vs SRL downstream.
- rd / rs1 / rs2  output  5 each  instr[11:7] / instr[19:15] / instr[24:20].
- imm_i  output  WORD_LENGTH  instr[31:20], sign-extended.
- illegal  output  1  instr_valid and opcode is neither 0010011 nor 0110011.
- instr_count  output  WORD_LENGTH  number of instructions consumed.

Behaviour:
- Reset values (synchronous, rst=1 at posedge): state=S_START; pc=RESET_PC; imem_req=0; instr_valid=0; instr=0; instr_count=0. rst overrides every other input in the same cycle.
- States:
  - S_START: one cycle only, imem_req=0. Next state is S_REQ and imem_req is set to 1.
  - S_REQ: imem_req=1 and imem_addr=pc, both held stable until ack. When imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, next state S_HOLD. When imem_ack=0: remain in S_REQ.
  - S_HOLD: instr_valid=1, with instr and pc frozen. When decode_ready=1: pc<=pc+4, instr_count<=instr_count+1, instr_valid<=0, imem_req<=1, next state S_REQ. When decode_ready=0: remain in S_HOLD.
- Latency:
  - An ack in the same cycle imem_req rises is legal. instr_valid is then asserted the following cycle.
  - First instr_valid is reached no earlier than 3 cycles after rst deasserts.
  - Peak throughput is one instruction per 2 cycles.
- imem_ack is ignored outside S_REQ; imem_rdata is never sampled outside an acked S_REQ cycle.
- decode_ready is ignored outside S_HOLD.
- Arithmetic:
  - pc+4 wraps modulo 2^WORD_LENGTH; 0xFFFFFFFC advances to 0x00000000.
  - instr_count wraps to 0 after all-ones.
- Decoded fields are combinational slices of the instr register. They are don't-care while instr_valid=0, except illegal, which is forced to 0.
- Reset mid-operation (rst in S_REQ or S_HOLD):
  - The in-flight request is abandoned.
  - An ack arriving in the same cycle as rst is discarded.
  - Fetch restarts from RESET_PC via S_START.
- No speculative or prefetch requests: at most one outstanding request; imem_req never toggles while waiting.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req): instr_valid high on the 3rd cycle after rst falls with imem_addr=0x0. decode_ready held 1 gives addresses 0x0, 0x4, 0x8 on alternating cycles; instr_count=3 after three consumes.
- Memory latency 3 cycles, rdata=0x40B50533 (sub a0,a0,a1): imem_req and imem_addr stay constant for 3 cycles. Then opcode=0110011, funct3=000, funct7=1, rd=10, rs1=10, rs2=11, illegal=0.
- Fetch 0xFFF00093 (addi x1,x0,-1) with decode_ready low for 5 cycles: instr, pc and imm_i=0xFFFFFFFF stay stable, imem_req=0, instr_count unchanged. On decode_ready=1, pc advances by 4.
- Fetch 0x00000073 (ecall): illegal=1 while held. A spurious imem_ack with rdata=0x12345678 during S_HOLD leaves instr unchanged.
- RESET_PC=0xFFFFFFFC: first fetch at 0xFFFFFFFC, second fetch at 0x00000000 (wrap).
- Assert rst in S_REQ in the same cycle as imem_ack: instr_valid stays 0, and the next request issues at RESET_PC after the S_START cycle.
